serial_rx: RTL
==============

# serial_rx

Serial frame receiver: the receive end of the team's single-wire serial link. It takes an idle-high line carrying start bit, LSB-first data, optional even parity and stop bit, and presents each frame as a parallel word. A valid/ack hold register buffers the word, and error flags report framing, parity and overrun faults. It sits between the board serial pin and the parallel datapath, and pairs with the transmit-side shift register.

## Interface
- DATA_BITS, 8, data bits per frame (legal 4..16)
- PARITY_EN, 0, 1 = one even-parity bit follows the data bits
- clk  in  1  system clock; all registers update on the falling edge
- clr  in  1  asynchronous, active-low reset
- rx  in  1  serial line, asynchronous to clk, idle high
- bit_en  in  1  bit-rate strobe, one clk period wide; the FSM acts only on falling edges where bit_en=1
- ack  in  1  consumer accepts data; effective only while valid=1
- data  out  DATA_BITS  last good frame payload
- valid  out  1  data holds an unconsumed frame
- par_err  out  1  parity result of the frame in data; updated together with data
- frame_err  out  1  one-cycle pulse when a stop bit samples 0
- overrun  out  1  sticky; a frame completed while valid=1 and was not acked on that edge

## Operation
- rx passes through a 2-flop synchronizer; the FSM samples only the synchronized value rx_s.
- States: IDLE, DATA, PARITY, STOP.
  - IDLE: on bit_en with rx_s=0, go to DATA and set cnt=0.
  - DATA: on bit_en, shift rx_s in at the MSB of shift (right shift, LSB-first), cnt++. When cnt=DATA_BITS-1, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: on bit_en, capture p=rx_s and go to STOP.
  - STOP, on bit_en with rx_s=1:
    - data <= shift
    - valid <= 1
    - par_err <= (^shift ^ p) when PARITY_EN=1, else 0
    - go to IDLE
  - STOP, on bit_en with rx_s=0: frame_err=1 for one clk, data/valid/par_err unchanged, go to IDLE.
- A break condition (line held 0) is received as repeated start bits. Each frame that completes in it raises frame_err.
- Handshake: on a falling edge with valid=1 and ack=1, valid <= 0. ack with valid=0 is ignored.
- Load and ack on the same edge: the load wins, valid stays 1, overrun does not set.
- Load with valid=1 and no ack: data is overwritten, valid stays 1, overrun <= 1. overrun clears only on reset.
- No start-bit glitch rejection: the start is decided by one sample.

## Timing
- Reset (clr=0, immediate): state=IDLE, cnt=0, shift=0, data=0, valid=0, par_err=0, frame_err=0, overrun=0, both synchronizer flops=1.
- Reset asserted mid-frame aborts the frame. After release, the receiver waits for a fresh start bit.
- Synchronizer latency: an rx change is visible to the FSM 2 falling edges later. bit_en must be placed at bit centre, accounting for that delay.
- Frame length is 2+DATA_BITS+PARITY_EN bit_en strobes. valid and data update on the falling edge of the stop-bit strobe.
- frame_err is high exactly one clk period, on the stop-bit strobe edge.
- bit_en=0 freezes the FSM in all states; ack is still honoured.

## Structure
- Shared package serial_pkg:
  - state typedef (IDLE, DATA, PARITY, STOP)
  - idle level (1), start level (0), stop level (1)
  - used by the transmit side too
- Sub-module sync_2ff: the 2-flop synchronizer, falling-edge, async active-low clr, reset value 1.
- Counter width is $clog2(DATA_BITS).

## Test plan
- Reset, then DATA_BITS=8, PARITY_EN=0, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) plus stop 1 -> data=0xA5, valid=1 after stop strobe, par_err=0, frame_err=0.
- Stop bit 0 on frame 0x3C -> frame_err pulses 1 clk, valid stays 0, data stays 0x00.
- PARITY_EN=1, send 0x07 with parity 0 (wrong) -> data=0x07, valid=1, par_err=1; resend with parity 1 -> par_err=0.
- Two frames 0x11, 0x22 with no ack -> data=0x22, valid=1, overrun=1. Repeat with ack on the 0x22 load edge -> overrun stays 0, valid=1.
- clr pulsed after 4 data bits of 0xFF, then a full 0x5A frame -> only 0x5A delivered, all outputs 0 during reset.
- Hold rx=0 for 30 strobes -> frame_err pulses on each stop strobe, valid stays 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (receive and transmit sides).
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } serial_state_e;

    localparam logic LVL_IDLE  = 1'b1;
    localparam logic LVL_START = 1'b0;
    localparam logic LVL_STOP  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop falling-edge synchronizer for the serial line; resets to the idle level.
module sync_2ff
    import serial_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            meta <= LVL_IDLE;
            q    <= LVL_IDLE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: start, LSB-first data, optional even parity, stop.
// Delivers frames through a valid/ack hold register with error flags.
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 rx,
    input  logic                 bit_en,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 par_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int            CW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BITS - 1);

    serial_state_e        state;
    logic [CW-1:0]        cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 p;
    logic                 rx_s;
    logic                 load;

    sync_2ff u_sync (
        .clk (clk),
        .clr (clr),
        .d   (rx),
        .q   (rx_s)
    );

    assign load = bit_en && (state == STOP) && (rx_s == LVL_STOP);

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            p         <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // A load on the same edge as ack keeps valid set; ack only counts against a held word.
            if (load) begin
                data    <= shift;
                valid   <= 1'b1;
                par_err <= PARITY_EN ? (^shift ^ p) : 1'b0;
                if (valid && !ack)
                    overrun <= 1'b1;
            end else if (valid && ack) begin
                valid <= 1'b0;
            end

            if (bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (rx_s == LVL_START) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        cnt   <= cnt + CW'(1);
                        if (cnt == CNT_LAST)
                            state <= PARITY_EN ? PARITY : STOP;
                    end
                    PARITY: begin
                        p     <= rx_s;
                        state <= STOP;
                    end
                    STOP: begin
                        if (rx_s != LVL_STOP)
                            frame_err <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
